// File: rtl/text_cmd_parser.sv
// Opcode-driven UART byte decoder producing screen-buffer write strobes, with cursor, colour attribute and clear sweep.
// Optional inter-byte operand timeout enabled by defining TEXT_CMD_TIMEOUT_EN.
module text_cmd_parser #(
    parameter int DATA_WIDTH     = 8,
    parameter int N_COL          = 128,
    parameter int N_ROW          = 48,
    parameter int COL_WIDTH      = 7,
    parameter int ROW_WIDTH      = 6,
    parameter int CHAR_WIDTH     = 7,
    parameter int ATTR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65000000
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  rx_valid_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    output logic                  wr_en_o,
    output logic [COL_WIDTH-1:0]  col_o,
    output logic [ROW_WIDTH-1:0]  row_o,
    output logic [CHAR_WIDTH-1:0] char_o,
    output logic [ATTR_WIDTH-1:0] attr_o,
    output logic [COL_WIDTH-1:0]  cur_col_o,
    output logic [ROW_WIDTH-1:0]  cur_row_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARG_COL  = 3'd1;
    localparam logic [2:0] S_ARG_ROW  = 3'd2;
    localparam logic [2:0] S_ARG_CHAR = 3'd3;
    localparam logic [2:0] S_ARG_ATTR = 3'd4;
    localparam logic [2:0] S_CLEAR    = 3'd5;

    localparam logic [2:0] OP_WRITE_AT   = 3'd1;
    localparam logic [2:0] OP_PUT        = 3'd2;
    localparam logic [2:0] OP_SET_CURSOR = 3'd5;

    localparam logic [DATA_WIDTH-1:0] BYTE_WRITE_AT   = DATA_WIDTH'(8'h01);
    localparam logic [DATA_WIDTH-1:0] BYTE_PUT        = DATA_WIDTH'(8'h02);
    localparam logic [DATA_WIDTH-1:0] BYTE_SET_ATTR   = DATA_WIDTH'(8'h03);
    localparam logic [DATA_WIDTH-1:0] BYTE_CLEAR      = DATA_WIDTH'(8'h04);
    localparam logic [DATA_WIDTH-1:0] BYTE_SET_CURSOR = DATA_WIDTH'(8'h05);
    localparam logic [DATA_WIDTH-1:0] BYTE_NEWLINE    = DATA_WIDTH'(8'h0A);

    localparam logic [COL_WIDTH-1:0]  COL_LAST   = COL_WIDTH'(N_COL - 1);
    localparam logic [ROW_WIDTH-1:0]  ROW_LAST   = ROW_WIDTH'(N_ROW - 1);
    localparam logic [CHAR_WIDTH-1:0] CHAR_SPACE = CHAR_WIDTH'(8'h20);
    localparam logic [ATTR_WIDTH-1:0] ATTR_RESET = ATTR_WIDTH'(8'hF0);

    logic [2:0]            state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic                  rx_valid_q;
    logic [COL_WIDTH-1:0]  arg_col_q, arg_col_d;
    logic [ROW_WIDTH-1:0]  arg_row_q, arg_row_d;
    logic [ATTR_WIDTH-1:0] attr_cur_q, attr_cur_d;
    logic                  wr_en_q, wr_en_d;
    logic [COL_WIDTH-1:0]  col_q, col_d;
    logic [ROW_WIDTH-1:0]  row_q, row_d;
    logic [CHAR_WIDTH-1:0] char_q, char_d;
    logic [ATTR_WIDTH-1:0] attr_q, attr_d;
    logic [COL_WIDTH-1:0]  cur_col_q, cur_col_d;
    logic [ROW_WIDTH-1:0]  cur_row_q, cur_row_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [COL_WIDTH-1:0]  clr_col_q, clr_col_d;
    logic [ROW_WIDTH-1:0]  clr_row_q, clr_row_d;

    logic byte_ev;
    logic col_in_range;
    logic row_in_range;
    logic in_arg_state;

    assign byte_ev      = rx_valid_i & ~rx_valid_q;
    // Range is checked on the whole byte so out-of-range values cannot alias onto a valid index.
    assign col_in_range = (32'(rx_data_i) < 32'(N_COL));
    assign row_in_range = (32'(rx_data_i) < 32'(N_ROW));
    assign in_arg_state = (state_q == S_ARG_COL) || (state_q == S_ARG_ROW) ||
                          (state_q == S_ARG_CHAR) || (state_q == S_ARG_ATTR);

    function automatic logic [ROW_WIDTH-1:0] row_next(input logic [ROW_WIDTH-1:0] r);
        return (r == ROW_LAST) ? '0 : r + 1'b1;
    endfunction

`ifdef TEXT_CMD_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        timeout_hit;

    assign timeout_hit = in_arg_state && !byte_ev && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = '0;
        if (in_arg_state && !byte_ev && !timeout_hit) begin
            to_cnt_d = to_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic timeout_hit;
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0) & in_arg_state;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        arg_col_d  = arg_col_q;
        arg_row_d  = arg_row_q;
        attr_cur_d = attr_cur_q;
        wr_en_d    = 1'b0;
        col_d      = col_q;
        row_d      = row_q;
        char_d     = char_q;
        attr_d     = attr_q;
        cur_col_d  = cur_col_q;
        cur_row_d  = cur_row_q;
        busy_d     = busy_q;
        err_d      = 1'b0;
        clr_col_d  = clr_col_q;
        clr_row_d  = clr_row_q;

        case (state_q)
            S_IDLE: begin
                if (byte_ev) begin
                    case (rx_data_i)
                        BYTE_WRITE_AT: begin
                            op_d    = OP_WRITE_AT;
                            state_d = S_ARG_COL;
                        end
                        BYTE_PUT: begin
                            op_d    = OP_PUT;
                            state_d = S_ARG_CHAR;
                        end
                        BYTE_SET_ATTR: begin
                            state_d = S_ARG_ATTR;
                        end
                        BYTE_CLEAR: begin
                            state_d   = S_CLEAR;
                            busy_d    = 1'b1;
                            clr_col_d = '0;
                            clr_row_d = '0;
                        end
                        BYTE_SET_CURSOR: begin
                            op_d    = OP_SET_CURSOR;
                            state_d = S_ARG_COL;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end

            S_ARG_COL: begin
                if (byte_ev) begin
                    if (!col_in_range) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        arg_col_d = rx_data_i[COL_WIDTH-1:0];
                        state_d   = S_ARG_ROW;
                    end
                end
            end

            S_ARG_ROW: begin
                if (byte_ev) begin
                    if (!row_in_range) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (op_q == OP_SET_CURSOR) begin
                        cur_col_d = arg_col_q;
                        cur_row_d = rx_data_i[ROW_WIDTH-1:0];
                        state_d   = S_IDLE;
                    end else begin
                        arg_row_d = rx_data_i[ROW_WIDTH-1:0];
                        state_d   = S_ARG_CHAR;
                    end
                end
            end

            S_ARG_CHAR: begin
                if (byte_ev) begin
                    state_d = S_IDLE;
                    if (op_q == OP_WRITE_AT) begin
                        wr_en_d = 1'b1;
                        col_d   = arg_col_q;
                        row_d   = arg_row_q;
                        char_d  = rx_data_i[CHAR_WIDTH-1:0];
                        attr_d  = attr_cur_q;
                    end else if (rx_data_i == BYTE_NEWLINE) begin
                        cur_col_d = '0;
                        cur_row_d = row_next(cur_row_q);
                    end else begin
                        wr_en_d = 1'b1;
                        col_d   = cur_col_q;
                        row_d   = cur_row_q;
                        char_d  = rx_data_i[CHAR_WIDTH-1:0];
                        attr_d  = attr_cur_q;
                        if (cur_col_q == COL_LAST) begin
                            cur_col_d = '0;
                            cur_row_d = row_next(cur_row_q);
                        end else begin
                            cur_col_d = cur_col_q + 1'b1;
                        end
                    end
                end
            end

            S_ARG_ATTR: begin
                if (byte_ev) begin
                    attr_cur_d = rx_data_i[ATTR_WIDTH-1:0];
                    state_d    = S_IDLE;
                end
            end

            S_CLEAR: begin
                // Bytes arriving mid-sweep are dropped; the sweep never stalls.
                if (byte_ev) begin
                    err_d = 1'b1;
                end
                wr_en_d = 1'b1;
                col_d   = clr_col_q;
                row_d   = clr_row_q;
                char_d  = CHAR_SPACE;
                attr_d  = attr_cur_q;
                if (clr_col_q == COL_LAST) begin
                    clr_col_d = '0;
                    if (clr_row_q == ROW_LAST) begin
                        clr_row_d = '0;
                        cur_col_d = '0;
                        cur_row_d = '0;
                        busy_d    = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        clr_row_d = clr_row_q + 1'b1;
                    end
                end else begin
                    clr_col_d = clr_col_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            rx_valid_q <= 1'b0;
            arg_col_q  <= '0;
            arg_row_q  <= '0;
            attr_cur_q <= ATTR_RESET;
            wr_en_q    <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            char_q     <= '0;
            attr_q     <= '0;
            cur_col_q  <= '0;
            cur_row_q  <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            clr_col_q  <= '0;
            clr_row_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rx_valid_q <= rx_valid_i;
            arg_col_q  <= arg_col_d;
            arg_row_q  <= arg_row_d;
            attr_cur_q <= attr_cur_d;
            wr_en_q    <= wr_en_d;
            col_q      <= col_d;
            row_q      <= row_d;
            char_q     <= char_d;
            attr_q     <= attr_d;
            cur_col_q  <= cur_col_d;
            cur_row_q  <= cur_row_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            clr_col_q  <= clr_col_d;
            clr_row_q  <= clr_row_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign col_o     = col_q;
    assign row_o     = row_q;
    assign char_o    = char_q;
    assign attr_o    = attr_q;
    assign cur_col_o = cur_col_q;
    assign cur_row_o = cur_row_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;

endmodule
